// File: rtl/tpx3_fifo_byte_streamer.sv
// Serialises 32-bit first-word-fall-through FIFO words into an 8-bit valid/ready
// byte stream at one byte per cycle, with a word counter and sticky stall flag.
module tpx3_fifo_byte_streamer #(
    parameter int LSB_FIRST    = 1,
    parameter int CNT_WIDTH    = 32,
    parameter int STALL_CYCLES = 1024
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST,
    input  logic                 ENABLE,
    input  logic                 CLR_CNT,
    input  logic                 FIFO_EMPTY,
    input  logic [31:0]          FIFO_DATA,
    output logic                 FIFO_READ,
    output logic [7:0]           TX_DATA,
    output logic                 TX_VALID,
    input  logic                 TX_READY,
    output logic [CNT_WIDTH-1:0] WORD_CNT,
    output logic                 STALL
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam logic [15:0]          STALL_LIM = 16'(STALL_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [1:0]           bidx_q, bidx_d;
    logic [31:0]          wreg_q, wreg_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [15:0]          stall_cnt_q, stall_cnt_d;
    logic                 stall_q, stall_d;

    logic                 busy_s;
    logic                 xfer_s;
    logic                 last_s;
    logic                 fifo_read_s;

    // Transmission order maps the stream index onto a physical byte lane.
    function automatic logic [7:0] sel_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [1:0] lane;
        logic [7:0] result;
        lane = (LSB_FIRST != 0) ? idx : (2'd3 - idx);
        case (lane)
            2'd0:    result = word[7:0];
            2'd1:    result = word[15:8];
            2'd2:    result = word[23:16];
            2'd3:    result = word[31:24];
            default: result = 8'h00;
        endcase
        return result;
    endfunction

    // Handshake decode and pop strobe; a pop on the last byte keeps the stream gap-free.
    always_comb begin
        busy_s      = (state_q == ST_SEND);
        xfer_s      = busy_s & TX_READY;
        last_s      = xfer_s & (bidx_q == 2'd3);
        fifo_read_s = BUS_RST & ENABLE & ~FIFO_EMPTY & (~busy_s | last_s);
    end

    // Next-state for the word register, byte index, output byte and send state.
    always_comb begin
        state_d   = state_q;
        bidx_d    = bidx_q;
        wreg_d    = wreg_q;
        tx_data_d = tx_data_q;
        if (fifo_read_s) begin
            state_d   = ST_SEND;
            bidx_d    = 2'd0;
            wreg_d    = FIFO_DATA;
            tx_data_d = sel_byte(FIFO_DATA, 2'd0);
        end else if (last_s) begin
            state_d = ST_IDLE;
            bidx_d  = 2'd0;
        end else if (xfer_s) begin
            bidx_d    = bidx_q + 2'd1;
            tx_data_d = sel_byte(wreg_q, bidx_q + 2'd1);
        end else begin
            state_d = state_q;
        end
    end

    // Word counter: clear has priority over a coincident completed word.
    always_comb begin
        word_cnt_d = word_cnt_q;
        if (CLR_CNT) begin
            word_cnt_d = '0;
        end else if (last_s) begin
            word_cnt_d = word_cnt_q + CNT_ONE;
        end else begin
            word_cnt_d = word_cnt_q;
        end
    end

    // Stall monitor: flag fires on reaching the limit, so a clear is not re-set while saturated.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        stall_d     = stall_q;
        if (!busy_s || xfer_s) begin
            stall_cnt_d = 16'd0;
        end else if (stall_cnt_q < STALL_LIM) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (CLR_CNT) begin
            stall_d = 1'b0;
        end else if ((stall_cnt_d == STALL_LIM) && (stall_cnt_q != STALL_LIM)) begin
            stall_d = 1'b1;
        end else begin
            stall_d = stall_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge BUS_CLK or negedge BUS_RST) begin
        if (!BUS_RST) begin
            state_q     <= ST_IDLE;
            bidx_q      <= 2'd0;
            wreg_q      <= 32'h0000_0000;
            tx_data_q   <= 8'h00;
            word_cnt_q  <= '0;
            stall_cnt_q <= 16'd0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bidx_q      <= bidx_d;
            wreg_q      <= wreg_d;
            tx_data_q   <= tx_data_d;
            word_cnt_q  <= word_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign FIFO_READ = fifo_read_s;
    assign TX_DATA   = tx_data_q;
    assign TX_VALID  = (state_q == ST_SEND);
    assign WORD_CNT  = word_cnt_q;
    assign STALL     = stall_q;

endmodule

// File: tb/tb_tpx3_fifo_byte_streamer.sv
// Directed bench for tpx3_fifo_byte_streamer: an LSB-first instance with a 32-bit
// counter and an MSB-first instance with a 4-bit counter share one FIFO model.
module tb_tpx3_fifo_byte_streamer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        clr_cnt;
    logic        tx_ready;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        fifo_read_l, fifo_read_m;
    logic        tx_valid_l, tx_valid_m;
    logic        stall_l, stall_m;
    logic [7:0]  tx_data_l, tx_data_m;
    logic [31:0] word_cnt_l;
    logic [3:0]  word_cnt_m;

    logic [31:0] mem [0:2047];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [31:0] words [0:3];

    int          n_chk  = 0;
    int          n_pass = 0;

    logic        cap_en   = 1'b0;
    logic [7:0]  rx [0:4095];
    int          rx_n     = 0;
    int          stab_err = 0;
    int          bad_rd   = 0;
    logic        prev_v   = 1'b0;
    logic        prev_r   = 1'b0;
    logic [7:0]  prev_d   = 8'h00;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_data  = mem[rd_ptr[10:0]];

    tpx3_fifo_byte_streamer #(.LSB_FIRST(1), .CNT_WIDTH(32), .STALL_CYCLES(8)) u_dut (
        .BUS_CLK(clk), .BUS_RST(rst_n), .ENABLE(enable), .CLR_CNT(clr_cnt),
        .FIFO_EMPTY(fifo_empty), .FIFO_DATA(fifo_data), .FIFO_READ(fifo_read_l),
        .TX_DATA(tx_data_l), .TX_VALID(tx_valid_l), .TX_READY(tx_ready),
        .WORD_CNT(word_cnt_l), .STALL(stall_l)
    );

    tpx3_fifo_byte_streamer #(.LSB_FIRST(0), .CNT_WIDTH(4), .STALL_CYCLES(8)) u_dut_msb (
        .BUS_CLK(clk), .BUS_RST(rst_n), .ENABLE(enable), .CLR_CNT(clr_cnt),
        .FIFO_EMPTY(fifo_empty), .FIFO_DATA(fifo_data), .FIFO_READ(fifo_read_m),
        .TX_DATA(tx_data_m), .TX_VALID(tx_valid_m), .TX_READY(tx_ready),
        .WORD_CNT(word_cnt_m), .STALL(stall_m)
    );

    // FIFO model pops on the LSB instance's strobe.
    always @(posedge clk) begin
        if (fifo_read_l) rd_ptr <= rd_ptr + 1;
    end

    // Stream monitor: capture accepted bytes, check hold-stability and illegal pops.
    always @(negedge clk) begin
        if (cap_en) begin
            if (tx_valid_l && tx_ready) begin
                rx[rx_n[11:0]] <= tx_data_l;
                rx_n           <= rx_n + 1;
            end
            if (prev_v && !prev_r && (!tx_valid_l || (tx_data_l != prev_d)))
                stab_err <= stab_err + 1;
        end
        if (fifo_read_l && fifo_empty) bad_rd <= bad_rd + 1;
        prev_v <= tx_valid_l;
        prev_r <= tx_ready;
        prev_d <= tx_data_l;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[10:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
        return 8'(w >> (8 * k));
    endfunction

    initial begin
        int base;
        int guard;
        int err;

        rst_n = 1'b0; enable = 1'b1; clr_cnt = 1'b0; tx_ready = 1'b1;
        words[0] = 32'h4433_2211;
        push(words[0]);
        repeat (3) begin
            cyc(); @(negedge clk);
            check_eq("rst_fifo_read", 32'(fifo_read_l), 32'd0);
            check_eq("rst_valid",     32'(tx_valid_l),  32'd0);
            check_eq("rst_data",      32'(tx_data_l),   32'd0);
            check_eq("rst_cnt",       word_cnt_l,       32'd0);
            check_eq("rst_stall",     32'(stall_l),     32'd0);
        end

        // single word, pop in cycle n, first byte in n+1
        cyc(); rst_n = 1'b1; @(negedge clk);
        check_eq("sw_pop",       32'(fifo_read_l), 32'd1);
        check_eq("sw_pop_msb",   32'(fifo_read_m), 32'd1);
        check_eq("sw_idle_vld",  32'(tx_valid_l),  32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(); @(negedge clk);
            check_eq("sw_valid", 32'(tx_valid_l), 32'd1);
            check_eq("sw_lsb",   32'(tx_data_l),  32'(byte_of(words[0], k)));
            check_eq("sw_msb",   32'(tx_data_m),  32'(byte_of(words[0], 3 - k)));
            check_eq("sw_nopop", 32'(fifo_read_l), 32'd0);
        end
        cyc(); @(negedge clk);
        check_eq("sw_end_vld", 32'(tx_valid_l), 32'd0);
        check_eq("sw_cnt",     word_cnt_l,      32'd1);

        // back-to-back words, no gaps
        words[0] = 32'hA0A1_A2A3; words[1] = 32'hB0B1_B2B3; words[2] = 32'hC0C1_C2C3;
        cyc(); push(words[0]); push(words[1]); push(words[2]); @(negedge clk);
        check_eq("b2b_pop0", 32'(fifo_read_l), 32'd1);
        for (int c = 1; c <= 12; c++) begin
            cyc(); @(negedge clk);
            check_eq("b2b_valid", 32'(tx_valid_l), 32'd1);
            check_eq("b2b_lsb", 32'(tx_data_l), 32'(byte_of(words[(c - 1) / 4], (c - 1) % 4)));
            check_eq("b2b_msb", 32'(tx_data_m), 32'(byte_of(words[(c - 1) / 4], 3 - ((c - 1) % 4))));
            check_eq("b2b_pop", 32'(fifo_read_l), 32'((c == 4) || (c == 8)));
        end
        cyc(); @(negedge clk);
        check_eq("b2b_end_vld", 32'(tx_valid_l), 32'd0);
        check_eq("b2b_cnt",     word_cnt_l,      32'd4);
        check_eq("b2b_cnt_msb", 32'(word_cnt_m), 32'd4);

        // ENABLE drop mid-word never truncates, and blocks the next pop
        words[0] = 32'h1234_5678; words[1] = 32'h9ABC_DEF0;
        cyc(); push(words[0]); push(words[1]); @(negedge clk);
        check_eq("en_pop0", 32'(fifo_read_l), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc(); if (k == 2) enable = 1'b0; @(negedge clk);
            check_eq("en_valid", 32'(tx_valid_l), 32'd1);
            check_eq("en_byte",  32'(tx_data_l),  32'(byte_of(words[0], k)));
            check_eq("en_nopop", 32'(fifo_read_l), 32'd0);
        end
        repeat (4) begin
            cyc(); @(negedge clk);
            check_eq("en_off_vld", 32'(tx_valid_l),  32'd0);
            check_eq("en_off_pop", 32'(fifo_read_l), 32'd0);
        end
        cyc(); enable = 1'b1; @(negedge clk);
        check_eq("en_on_pop", 32'(fifo_read_l), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc(); @(negedge clk);
            check_eq("en_w1_byte", 32'(tx_data_l), 32'(byte_of(words[1], k)));
        end
        cyc(); @(negedge clk);
        check_eq("en_end_vld", 32'(tx_valid_l), 32'd0);
        check_eq("en_cnt",     word_cnt_l,      32'd6);

        // stall: 8 cycles of back-pressure sets STALL, data held
        words[0] = 32'h55AA_33CC;
        cyc(); tx_ready = 1'b0; push(words[0]); @(negedge clk);
        check_eq("st_pop", 32'(fifo_read_l), 32'd1);
        for (int c = 1; c <= 9; c++) begin
            cyc(); @(negedge clk);
            check_eq("st_valid", 32'(tx_valid_l), 32'd1);
            check_eq("st_hold",  32'(tx_data_l),  32'h0000_00CC);
            check_eq("st_flag",  32'(stall_l),    32'(c == 9));
        end
        check_eq("st_flag_msb", 32'(stall_m), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc(); if (k == 0) tx_ready = 1'b1; @(negedge clk);
            check_eq("st_byte",   32'(tx_data_l), 32'(byte_of(words[0], k)));
            check_eq("st_sticky", 32'(stall_l),   32'd1);
        end
        cyc(); @(negedge clk);
        check_eq("st_cnt", word_cnt_l, 32'd7);
        cyc(); clr_cnt = 1'b1;
        cyc(); clr_cnt = 1'b0; @(negedge clk);
        check_eq("clr_stall",   32'(stall_l),    32'd0);
        check_eq("clr_cnt",     word_cnt_l,      32'd0);
        check_eq("clr_cnt_msb", 32'(word_cnt_m), 32'd0);

        // CLR_CNT coincident with LAST: clear wins
        words[0] = 32'h0F0E_0D0C;
        cyc(); push(words[0]); @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            cyc(); if (k == 3) clr_cnt = 1'b1; @(negedge clk);
            check_eq("cl_byte", 32'(tx_data_l), 32'(byte_of(words[0], k)));
        end
        cyc(); clr_cnt = 1'b0; @(negedge clk);
        check_eq("cl_last_cnt",     word_cnt_l,      32'd0);
        check_eq("cl_last_cnt_msb", 32'(word_cnt_m), 32'd0);

        // counter wrap on the 4-bit instance
        cyc();
        for (int i = 0; i < 15; i++) push(32'h0101_0101 * i);
        repeat (70) cyc();
        @(negedge clk);
        check_eq("wrap_pre_msb", 32'(word_cnt_m), 32'd15);
        check_eq("wrap_pre_lsb", word_cnt_l,      32'd15);
        cyc(); push(32'hDEAD_BEEF);
        repeat (8) cyc();
        @(negedge clk);
        check_eq("wrap_msb", 32'(word_cnt_m), 32'd0);
        check_eq("wrap_lsb", word_cnt_l,      32'd16);

        // asynchronous reset mid-word discards it; next word starts at byte0
        words[0] = 32'h0D0C_0B0A; words[1] = 32'h1D1C_1B1A;
        cyc(); push(words[0]); push(words[1]); @(negedge clk);
        check_eq("ar_pop", 32'(fifo_read_l), 32'd1);
        cyc(); @(negedge clk);
        check_eq("ar_b0", 32'(tx_data_l), 32'h0000_000A);
        cyc(); rst_n = 1'b0; #1;
        check_eq("ar_valid", 32'(tx_valid_l),  32'd0);
        check_eq("ar_data",  32'(tx_data_l),   32'd0);
        check_eq("ar_pop0",  32'(fifo_read_l), 32'd0);
        check_eq("ar_cnt",   word_cnt_l,       32'd0);
        cyc(); rst_n = 1'b1; @(negedge clk);
        check_eq("ar_repop", 32'(fifo_read_l), 32'd1);
        for (int k = 0; k < 4; k++) begin
            cyc(); @(negedge clk);
            check_eq("ar_valid2", 32'(tx_valid_l), 32'd1);
            check_eq("ar_byte",   32'(tx_data_l),  32'(byte_of(words[1], k)));
        end
        cyc(); @(negedge clk);
        check_eq("ar_end_vld", 32'(tx_valid_l), 32'd0);
        check_eq("ar_cnt2",    word_cnt_l,      32'd1);

        // random back-pressure over 1000 words
        cyc(); clr_cnt = 1'b1;
        cyc(); clr_cnt = 1'b0;
        base = wr_ptr;
        for (int i = 0; i < 1000; i++) push($urandom);
        cap_en = 1'b1;
        guard  = 0;
        do begin
            cyc();
            tx_ready = 1'($urandom_range(0, 1));
            guard++;
        end while (!(fifo_empty && !tx_valid_l) && (guard < 20000));
        @(negedge clk);
        cap_en = 1'b0;
        tx_ready = 1'b1;
        check_eq("bp_done", 32'(guard < 20000), 32'd1);
        check_eq("bp_count", rx_n, 32'd4000);
        err = 0;
        for (int i = 0; i < 1000; i++)
            for (int b = 0; b < 4; b++)
                if (rx[(4 * i + b) % 4096] != byte_of(mem[(base + i) % 2048], b)) err++;
        check_eq("bp_bytes",     err,        32'd0);
        check_eq("bp_stable",    stab_err,   32'd0);
        check_eq("no_empty_pop", bad_rd,     32'd0);
        check_eq("bp_cnt",       word_cnt_l, 32'd1000);
        check_eq("bp_cnt_msb",   32'(word_cnt_m), 32'd8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
